// File: rtl/mem_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream and memory-port signals for mem_burst_ctrl.
// The controller uses the slave view; the surrounding datapath/memory model uses master.
interface mem_burst_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 14,
   parameter int LEN_W  = 11
);
   logic              start;
   logic              op;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  start, op, base_addr, len, s_valid, s_data, m_ready, mem_rdata,
      output busy, done, s_ready, m_valid, m_data, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
   );

   modport master (
      output start, op, base_addr, len, s_valid, s_data, m_ready, mem_rdata,
      input  busy, done, s_ready, m_valid, m_data, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller for the single-port sample memory: stream-to-memory writes and
// memory-to-stream reads through a 4-entry output FIFO.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_WRITE | accepting stream words, one memory write per handshake
//   ST_READ  | issuing memory reads while FIFO space allows
//   ST_DRAIN | all reads issued, waiting for FIFO and in-flight read to empty
//   ST_DONE  | one-cycle completion pulse, accepts start like IDLE
module mem_burst_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 14,
   parameter int LEN_W  = 11
) (
   input logic             iclk,
   input logic             irst,
   mem_burst_ctrl_if.slave bus
);
   typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_pend_q;
   logic [DATA_W-1:0] fifo_q [4];
   logic [1:0]        rd_ptr_q, wr_ptr_q;
   logic [2:0]        count_q, count_d;
   logic [2:0]        occ;
   logic              rd_issue, push, pop;

   // Read data returns one cycle after issue, so at most one read is ever in flight.
   assign occ     = count_q + {2'b00, rd_pend_q};
   assign push    = rd_pend_q;
   assign pop     = (count_q != 3'd0) && bus.m_ready;
   assign count_d = count_q + {2'b00, push} - {2'b00, pop};

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      rd_issue  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               addr_d = bus.base_addr;
               rem_d  = bus.len;
               if (bus.len == '0)  state_d = ST_DONE;
               else if (bus.op)    state_d = ST_READ;
               else                state_d = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (bus.s_valid && (rem_q != '0)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wdata_d   = bus.s_data;
               addr_d    = addr_q + ADDR_ONE;
               rem_d     = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) state_d = ST_DONE;
            end
         end
         ST_READ: begin
            rd_issue = (rem_q != '0) && (occ < 3'd4);
            if (rd_issue) begin
               addr_d = addr_q + ADDR_ONE;
               rem_d  = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!rd_pend_q && (count_d == 3'd0)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         rd_pend_q <= rd_issue;
         count_q   <= count_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_rdata;
            wr_ptr_q         <= wr_ptr_q + 2'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      end
   end

   // Reads are issued combinationally so the first read goes out the cycle after start.
   assign bus.busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.s_ready   = (state_q == ST_WRITE) && (rem_q != '0);
   assign bus.m_valid   = (count_q != 3'd0);
   assign bus.m_data    = fifo_q[rd_ptr_q];
   assign bus.mem_wr_en = wr_en_q;
   assign bus.mem_rd_en = rd_issue;
   assign bus.mem_addr  = rd_issue ? addr_q : wr_addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: memory model, stream drivers, and a reference
// model built from expected address sequences and a shadow copy of memory contents.
module tb_mem_burst_ctrl;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 14;
   localparam int LEN_W  = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   logic iclk = 1'b0;
   logic irst = 1'b0;
   int   cyc  = 0;

   mem_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   mem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .iclk(iclk),
      .irst(irst),
      .bus (bus)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] mem_arr [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                loaded = 1'b0;

   always @(posedge iclk) begin
      if (!loaded) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] <= ref_mem[i];
         loaded <= 1'b1;
      end else begin
         if (bus.mem_wr_en) mem_arr[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_rd_en) bus.mem_rdata <= mem_arr[bus.mem_addr];
      end
   end

   int wr_addr_l[$], wr_data_l[$], wr_cyc_l[$], rd_data_l[$], rd_cyc_l[$], done_l[$];
   int issued, delivered, both_cnt, occ_err, stall_err, busy_cnt, busy_done_err;
   int first_busy, first_sready;
   bit stalled = 1'b0;
   logic [DATA_W-1:0] stall_data;
   int wq[$];

   always @(negedge iclk) begin
      if (irst) begin
         if (bus.mem_wr_en && bus.mem_rd_en) both_cnt++;
         if (bus.mem_wr_en) begin
            wr_addr_l.push_back(int'(bus.mem_addr));
            wr_data_l.push_back(int'(bus.mem_wdata));
            wr_cyc_l.push_back(cyc);
         end
         if (bus.mem_rd_en) issued++;
         if (issued - delivered > 4) occ_err++;
         if (stalled && (!bus.m_valid || bus.m_data !== stall_data)) stall_err++;
         stalled    = bus.m_valid && !bus.m_ready;
         stall_data = bus.m_data;
         if (bus.m_valid && bus.m_ready) begin
            rd_data_l.push_back(int'(bus.m_data));
            rd_cyc_l.push_back(cyc);
            delivered++;
         end
         if (bus.busy) busy_cnt++;
         if (bus.busy && first_busy < 0) first_busy = cyc;
         if (bus.s_ready && first_sready < 0) first_sready = cyc;
         if (bus.done) begin
            done_l.push_back(cyc);
            if (bus.busy) busy_done_err++;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic clear_logs();
      wr_addr_l.delete(); wr_data_l.delete(); wr_cyc_l.delete();
      rd_data_l.delete(); rd_cyc_l.delete(); done_l.delete();
      issued = 0; delivered = 0; both_cnt = 0; occ_err = 0; stall_err = 0;
      busy_cnt = 0; busy_done_err = 0; first_busy = -1; first_sready = -1;
   endtask

   // Issue one command and run the streams until done is seen.
   // vmode: 0 s_valid held, 1 random. rmode: 0 m_ready held, 1 pattern 1,0,0,1, 2 random.
   task automatic do_burst(input bit op_b, input int base, input int n, input int vmode,
                           input int rmode, input bit poke, output int t0, output bit tmo);
      int idx = 0;
      bit hs;
      int j;
      clear_logs();
      @(posedge iclk); #1;
      bus.start = 1'b1; bus.op = op_b;
      bus.base_addr = ADDR_W'(base); bus.len = LEN_W'(n);
      bus.s_valid = 1'b0; bus.m_ready = 1'b0;
      t0 = cyc; tmo = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge iclk);
         hs = bus.s_valid && bus.s_ready;
         @(posedge iclk); #1;
         if (hs) idx++;
         bus.start = 1'b0;
         if (poke && cyc == t0 + 2) begin
            bus.start = 1'b1; bus.op = ~op_b;
            bus.base_addr = ADDR_W'(base + 100); bus.len = LEN_W'(7);
         end
         bus.s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.s_data  = (idx < wq.size()) ? DATA_W'(wq[idx]) : '0;
         j = cyc - t0 - 1;
         case (rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ((j % 4) == 0) || ((j % 4) == 3);
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         if (done_l.size() > 0) begin
            tmo = 1'b0;
            break;
         end
      end
      bus.start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 0; bus.op = 0; bus.base_addr = '0; bus.len = '0;
      bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;
      irst = 1'b0;
      repeat (3) @(posedge iclk);
      #2;
      tests_run++;
      if ({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_data, bus.mem_wr_en,
           bus.mem_rd_en, bus.mem_addr, bus.mem_wdata} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b done=%b s_ready=%b m_valid=%b addr=%0d expected all 0",
                  bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.mem_addr);
      end
      irst = 1'b1;
      repeat (3) @(posedge iclk);
      #2;
      tests_run++;
      if ({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.mem_wr_en, bus.mem_rd_en} !== '0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: busy=%b done=%b s_ready=%b expected 0", bus.busy, bus.done, bus.s_ready);
      end
   endtask

   task automatic test_write_basic();
      int t0; bit tmo;
      wq = '{'h11, 'h22, 'h33};
      do_burst(1'b0, 5, 3, 0, 0, 1'b0, t0, tmo);
      for (int i = 0; i < 3; i++) ref_mem[5 + i] = DATA_W'(wq[i]);
      tests_run++;
      if (tmo !== 1'b0) begin tests_failed++; $display("FAIL wr_basic_timeout: done not seen"); end
      tests_run++;
      if (first_busy !== t0 + 1 || first_sready !== t0 + 1) begin
         tests_failed++;
         $display("FAIL wr_basic_busy_sready: busy@%0d s_ready@%0d expected %0d", first_busy, first_sready, t0 + 1);
      end
      tests_run++;
      if (wr_addr_l.size() !== 3) begin
         tests_failed++; $display("FAIL wr_basic_count: got %0d expected 3", wr_addr_l.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (wr_addr_l[i] !== 5 + i || wr_data_l[i] !== wq[i] || wr_cyc_l[i] !== t0 + 2 + i) begin
               tests_failed++;
               $display("FAIL wr_basic_word%0d: addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                        i, wr_addr_l[i], wr_data_l[i], wr_cyc_l[i], 5 + i, wq[i], t0 + 2 + i);
            end
         end
      end
      tests_run++;
      if (done_l.size() !== 1 || done_l[0] !== t0 + 4 || busy_done_err !== 0 || both_cnt !== 0) begin
         tests_failed++;
         $display("FAIL wr_basic_done: done@%0d busy_at_done=%0d expected done@%0d busy 0",
                  (done_l.size() > 0) ? done_l[0] : -1, busy_done_err, t0 + 4);
      end
   endtask

   task automatic test_read_basic();
      int t0; bit tmo;
      do_burst(1'b1, 5, 3, 0, 0, 1'b0, t0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || rd_data_l.size() !== 3) begin
         tests_failed++; $display("FAIL rd_basic_count: got %0d words timeout=%0b expected 3", rd_data_l.size(), tmo);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rd_data_l[i] !== int'(ref_mem[5 + i]) || rd_cyc_l[i] !== t0 + 3 + i) begin
               tests_failed++;
               $display("FAIL rd_basic_word%0d: data=%0h cyc=%0d expected data=%0h cyc=%0d",
                        i, rd_data_l[i], rd_cyc_l[i], ref_mem[5 + i], t0 + 3 + i);
            end
         end
      end
      tests_run++;
      if (done_l.size() !== 1 || done_l[0] !== t0 + 6 || wr_addr_l.size() !== 0) begin
         tests_failed++;
         $display("FAIL rd_basic_done: done@%0d writes=%0d expected done@%0d writes 0",
                  (done_l.size() > 0) ? done_l[0] : -1, wr_addr_l.size(), t0 + 6);
      end
   endtask

   task automatic test_read_stall();
      int t0; bit tmo;
      do_burst(1'b1, 0, 8, 0, 1, 1'b0, t0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || rd_data_l.size() !== 8) begin
         tests_failed++; $display("FAIL rd_stall_count: got %0d words timeout=%0b expected 8", rd_data_l.size(), tmo);
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (rd_data_l[i] !== int'(ref_mem[i])) begin
               tests_failed++;
               $display("FAIL rd_stall_word%0d: data=%0h expected %0h", i, rd_data_l[i], ref_mem[i]);
            end
         end
         tests_run++;
         if (done_l.size() !== 1 || done_l[0] !== rd_cyc_l[7] + 1) begin
            tests_failed++;
            $display("FAIL rd_stall_done: done@%0d expected %0d", (done_l.size() > 0) ? done_l[0] : -1, rd_cyc_l[7] + 1);
         end
      end
      tests_run++;
      if (stall_err !== 0 || occ_err !== 0 || both_cnt !== 0) begin
         tests_failed++;
         $display("FAIL rd_stall_rules: stall_err=%0d occ_err=%0d both=%0d expected 0", stall_err, occ_err, both_cnt);
      end
   endtask

   task automatic test_wrap();
      int t0; bit tmo;
      wq.delete();
      for (int i = 0; i < 4; i++) wq.push_back(int'($urandom_range(0, 16383)));
      do_burst(1'b0, 1022, 4, 1, 0, 1'b0, t0, tmo);
      for (int i = 0; i < 4; i++) ref_mem[(1022 + i) % DEPTH] = DATA_W'(wq[i]);
      tests_run++;
      if (tmo !== 1'b0 || wr_addr_l.size() !== 4) begin
         tests_failed++; $display("FAIL wrap_count: got %0d writes expected 4", wr_addr_l.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (wr_addr_l[i] !== (1022 + i) % DEPTH || wr_data_l[i] !== wq[i]) begin
               tests_failed++;
               $display("FAIL wrap_word%0d: addr=%0d data=%0h expected addr=%0d data=%0h",
                        i, wr_addr_l[i], wr_data_l[i], (1022 + i) % DEPTH, wq[i]);
            end
         end
         tests_run++;
         if (done_l.size() !== 1 || done_l[0] !== wr_cyc_l[3]) begin
            tests_failed++; $display("FAIL wrap_done: done@%0d expected %0d", (done_l.size() > 0) ? done_l[0] : -1, wr_cyc_l[3]);
         end
      end
      do_burst(1'b1, 1022, 4, 0, 2, 1'b0, t0, tmo);
      tests_run++;
      if (rd_data_l.size() !== 4) begin
         tests_failed++; $display("FAIL wrap_readback_count: got %0d expected 4", rd_data_l.size());
      end else if (rd_data_l[0] !== wq[0] || rd_data_l[1] !== wq[1] || rd_data_l[2] !== wq[2] || rd_data_l[3] !== wq[3]) begin
         tests_failed++;
         $display("FAIL wrap_readback: got %0h %0h %0h %0h expected %0h %0h %0h %0h",
                  rd_data_l[0], rd_data_l[1], rd_data_l[2], rd_data_l[3], wq[0], wq[1], wq[2], wq[3]);
      end
   endtask

   task automatic test_len0_and_ignore();
      int t0; bit tmo;
      do_burst(1'b0, 9, 0, 0, 0, 1'b0, t0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || done_l[0] !== t0 + 1 || busy_cnt !== 0 || wr_addr_l.size() !== 0 || issued !== 0) begin
         tests_failed++;
         $display("FAIL len0: done@%0d busy_cycles=%0d writes=%0d reads=%0d expected done@%0d and no activity",
                  (done_l.size() > 0) ? done_l[0] : -1, busy_cnt, wr_addr_l.size(), issued, t0 + 1);
      end
      wq = '{'h155, 'h2AA};
      do_burst(1'b0, 50, 2, 0, 0, 1'b1, t0, tmo);
      ref_mem[50] = DATA_W'(wq[0]);
      ref_mem[51] = DATA_W'(wq[1]);
      repeat (8) @(posedge iclk);
      #1;
      tests_run++;
      if (wr_addr_l.size() !== 2 || wr_addr_l[0] !== 50 || wr_addr_l[1] !== 51 || done_l.size() !== 1 || issued !== 0) begin
         tests_failed++;
         $display("FAIL start_ignored: writes=%0d dones=%0d reads=%0d expected 2 writes at 50,51, 1 done, 0 reads",
                  wr_addr_l.size(), done_l.size(), issued);
      end
   endtask

   task automatic test_random();
      int t0, base, n; bit tmo;
      for (int it = 0; it < 6; it++) begin
         base = int'($urandom_range(0, DEPTH - 1));
         n    = int'($urandom_range(1, 24));
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(int'($urandom_range(0, 16383)));
         do_burst(1'b0, base, n, 1, 0, 1'b0, t0, tmo);
         for (int i = 0; i < n; i++) ref_mem[(base + i) % DEPTH] = DATA_W'(wq[i]);
         tests_run++;
         if (tmo !== 1'b0 || wr_addr_l.size() !== n || done_l[0] !== wr_cyc_l[n - 1]) begin
            tests_failed++;
            $display("FAIL rand_wr%0d: writes=%0d timeout=%0b expected %0d writes, done on last write", it, wr_addr_l.size(), tmo, n);
         end
         do_burst(1'b1, base, n, 0, 2, 1'b0, t0, tmo);
         tests_run++;
         if (tmo !== 1'b0 || rd_data_l.size() !== n || done_l[0] !== rd_cyc_l[n - 1] + 1) begin
            tests_failed++;
            $display("FAIL rand_rd%0d: words=%0d timeout=%0b expected %0d words, done after last handshake", it, rd_data_l.size(), tmo, n);
         end else begin
            for (int i = 0; i < n; i++) begin
               tests_run++;
               if (rd_data_l[i] !== int'(ref_mem[(base + i) % DEPTH])) begin
                  tests_failed++;
                  $display("FAIL rand_rd%0d_word%0d: data=%0h expected %0h", it, i, rd_data_l[i], ref_mem[(base + i) % DEPTH]);
               end
            end
         end
         tests_run++;
         if (stall_err !== 0 || occ_err !== 0 || both_cnt !== 0) begin
            tests_failed++;
            $display("FAIL rand_rules%0d: stall_err=%0d occ_err=%0d both=%0d expected 0", it, stall_err, occ_err, both_cnt);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      int t0; bit tmo; bit reached = 1'b0;
      clear_logs();
      @(posedge iclk); #1;
      bus.start = 1'b1; bus.op = 1'b1; bus.base_addr = ADDR_W'(0); bus.len = LEN_W'(6);
      @(posedge iclk); #1;
      bus.start = 1'b0; bus.m_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (rd_data_l.size() >= 2) begin reached = 1'b1; break; end
         @(posedge iclk); #1;
      end
      tests_run++;
      if (!reached) begin tests_failed++; $display("FAIL rst_mid_progress: only %0d words before budget expected 2", rd_data_l.size()); end
      #2;
      irst = 1'b0;
      #1;
      tests_run++;
      if ({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_data, bus.mem_wr_en,
           bus.mem_rd_en, bus.mem_addr, bus.mem_wdata} !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_outputs: busy=%b m_valid=%b rd_en=%b addr=%0d expected all 0",
                  bus.busy, bus.m_valid, bus.mem_rd_en, bus.mem_addr);
      end
      bus.m_ready = 1'b0;
      repeat (2) @(posedge iclk);
      #3;
      irst = 1'b1;
      wq = '{'h1234};
      do_burst(1'b0, 0, 1, 0, 0, 1'b0, t0, tmo);
      ref_mem[0] = DATA_W'(wq[0]);
      tests_run++;
      if (tmo !== 1'b0 || wr_addr_l.size() !== 1 || wr_addr_l[0] !== 0 || wr_data_l[0] !== 'h1234 || done_l[0] !== t0 + 2) begin
         tests_failed++;
         $display("FAIL rst_mid_recover: writes=%0d done@%0d expected 1 write of 1234 at 0, done@%0d",
                  wr_addr_l.size(), (done_l.size() > 0) ? done_l[0] : -1, t0 + 2);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'($urandom_range(0, 16383));
      test_reset();
      test_write_basic();
      test_read_basic();
      test_read_stall();
      test_wrap();
      test_len0_and_ignore();
      test_random();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
